// File: rtl/fetch_unit.sv
// Fetch unit: program counter sequencing with an IDLE/RUN/HALTED control FSM,
// an 8-entry branch-target table and a saturating retired-instruction counter.
module fetch_unit #(
    parameter int unsigned PC_BITS  = 12,
    parameter int unsigned START_PC = 0,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    input  logic                halt_req,
    input  logic                branch_taken,
    input  logic [2:0]          branch_idx,
    input  logic                lut_we,
    input  logic [2:0]          lut_addr,
    input  logic [PC_BITS-1:0]  lut_wdata,
    output logic [PC_BITS-1:0]  pc,
    output logic                running,
    output logic                done,
    output logic [CNT_BITS-1:0] icount
);

    localparam int unsigned          TBL_DEPTH  = 8;
    localparam logic [PC_BITS-1:0]  START_ADDR = PC_BITS'(START_PC);
    localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PC_BITS-1:0]  pc_q, pc_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] cnt_inc;
    logic                running_q, done_q;
    logic [PC_BITS-1:0]  tbl_q [TBL_DEPTH];

    // Counter increment that sticks at all-ones instead of wrapping
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_BITS'(1);

    // Next-state, next-pc and next-count selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    cnt_d = cnt_inc;
                    if (halt_req) begin
                        state_d = S_HALTED;
                    end else if (branch_taken) begin
                        pc_d = tbl_q[branch_idx];
                    end else begin
                        pc_d = pc_q + PC_BITS'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, pc, counter and decoded status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= START_ADDR;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_HALTED);
        end
    end

    // Branch-target table; a same-edge branch reads the old entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (lut_we) begin
            tbl_q[lut_addr] <= lut_wdata;
        end
    end

    assign pc      = pc_q;
    assign running = running_q;
    assign done    = done_q;
    assign icount  = cnt_q;

endmodule
